// File: rtl/ifq_pkg.sv
// Shared types and bus layout for the instruction fetch queue.
// IFQ_ADEF_EN enables the fetch-address alignment exception.
package ifq_pkg;

    localparam int IF_TO_ID_BUS_W = 71;
    localparam logic [5:0] ECODE_ADEF = 6'h08;

    localparam int BUS_ECODE_LSB = 0;
    localparam int BUS_EXC_BIT   = 6;
    localparam int BUS_PC_LSB    = 7;
    localparam int BUS_INST_LSB  = 39;

    typedef logic [IF_TO_ID_BUS_W-1:0] if_to_id_t;

    function automatic if_to_id_t pack_entry(
        input logic [31:0] inst,
        input logic [31:0] pc,
        input logic        exc,
        input logic [5:0]  ecode
    );
        return {inst, pc, exc, ecode};
    endfunction

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Fetch-side SRAM handshake, redirect and IF->ID handoff signals.
// IFQ_ADEF_EN does not change this interface.
interface inst_fetch_queue_if;
    import ifq_pkg::*;

    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_allowin;
    logic        if_to_id_valid;
    if_to_id_t   if_to_id_bus;

    modport master (
        output inst_sram_req, inst_sram_addr,
        output if_to_id_valid, if_to_id_bus,
        input  inst_sram_addr_ok, inst_sram_data_ok,
        input  inst_sram_rdata, redirect, redirect_pc,
        input  id_allowin
    );

    modport slave (
        input  inst_sram_req, inst_sram_addr,
        input  if_to_id_valid, if_to_id_bus,
        output inst_sram_addr_ok, inst_sram_data_ok,
        output inst_sram_rdata, redirect, redirect_pc,
        output id_allowin
    );

endinterface

// File: rtl/ifq_fifo.sv
// Generic FIFO with flush, used for pending PCs and the instruction buffer.
// Depth need not be a power of two; pointers wrap at DEPTH.
module ifq_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    input  logic          flush,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= nxt(wr_ptr);
            if (do_pop)  rd_ptr <= nxt(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: issues in-order SRAM fetches and buffers results.
// Define IFQ_ADEF_EN to raise an address-alignment exception on bad PCs.
module inst_fetch_queue
    import ifq_pkg::*;
#(
    parameter int          OUTSTANDING = 2,
    parameter int          IBUF_DEPTH  = 4,
    parameter logic [31:0] RESET_PC    = 32'h1c000000
) (
    input  logic clk,
    input  logic reset,
    inst_fetch_queue_if.master ifq
);

    localparam int IW = $clog2(OUTSTANDING) + 1;
    localparam int BW = $clog2(IBUF_DEPTH) + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   pend_pc;
    logic [IW-1:0] inflight;
    logic [IW-1:0] inflight_nxt;
    logic [IW-1:0] cancel_cnt;
    logic [BW-1:0] ibuf_cnt;
    logic          room;
    logic          accept;
    logic          drop;
    logic          ib_push;
    logic          ib_pop;
    logic          ib_valid;
    logic          misalign;
    logic          adef_hold;
    logic          adef_push;
    if_to_id_t     ib_din;
    if_to_id_t     ib_dout;

`ifdef IFQ_ADEF_EN
    assign misalign  = |fetch_pc[1:0];
    assign adef_push = misalign & ~adef_hold & ~ifq.redirect
                     & (inflight == '0) & (cancel_cnt == '0)
                     & (32'(ibuf_cnt) < IBUF_DEPTH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)             adef_hold <= 1'b0;
        else if (ifq.redirect) adef_hold <= 1'b0;
        else if (adef_push)    adef_hold <= 1'b1;
    end
`else
    assign misalign  = 1'b0;
    assign adef_hold = 1'b0;
    assign adef_push = 1'b0;
`endif

    // Reserve buffer space for every in-flight request so nothing overflows
    assign room = (32'(inflight) < OUTSTANDING)
                & (32'(inflight) + 32'(ibuf_cnt) < IBUF_DEPTH);

    assign ifq.inst_sram_req  = room & ~ifq.redirect & ~adef_hold
                              & ~misalign & ~reset;
    assign ifq.inst_sram_addr = fetch_pc;

    assign accept       = ifq.inst_sram_req & ifq.inst_sram_addr_ok;
    assign drop         = (cancel_cnt != '0) | ifq.redirect;
    assign inflight_nxt = inflight + IW'(accept)
                        - IW'(ifq.inst_sram_data_ok);

    assign ib_push = (ifq.inst_sram_data_ok & ~drop) | adef_push;
    assign ib_din  = adef_push
                   ? pack_entry(32'h0, fetch_pc, 1'b1, ECODE_ADEF)
                   : pack_entry(ifq.inst_sram_rdata, pend_pc, 1'b0, 6'h0);
    assign ib_valid = (ibuf_cnt != '0);
    assign ib_pop   = ib_valid & ifq.id_allowin;

    assign ifq.if_to_id_valid = ib_valid;
    assign ifq.if_to_id_bus   = ib_valid ? ib_dout : '0;

    ifq_fifo #(.W(32), .DEPTH(OUTSTANDING), .CW(IW)) u_pend (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .din   (fetch_pc),
        .pop   (ifq.inst_sram_data_ok),
        .flush (1'b0),
        .dout  (pend_pc),
        .count (inflight)
    );

    ifq_fifo #(.W(IF_TO_ID_BUS_W), .DEPTH(IBUF_DEPTH), .CW(BW)) u_ibuf (
        .clk   (clk),
        .reset (reset),
        .push  (ib_push),
        .din   (ib_din),
        .pop   (ib_pop),
        .flush (ifq.redirect),
        .dout  (ib_dout),
        .count (ibuf_cnt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
        end else if (ifq.redirect) begin
            fetch_pc <= ifq.redirect_pc;
        end else if (accept) begin
            fetch_pc <= fetch_pc + 32'd4;
        end
    end

    // Everything still in flight after a redirect belongs to the old path
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cancel_cnt <= '0;
        end else if (ifq.redirect) begin
            cancel_cnt <= inflight_nxt;
        end else if (ifq.inst_sram_data_ok && cancel_cnt != '0) begin
            cancel_cnt <= cancel_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomized self-checking bench for inst_fetch_queue against a queue model.
// Build with IFQ_ADEF_EN to exercise the alignment exception path.
module tb_inst_fetch_queue;
    import ifq_pkg::*;

    localparam int          OUT   = 2;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h1c000000;

    typedef struct {
        logic [31:0] pc;
        bit          cxl;
    } pend_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    inst_fetch_queue_if ifq ();

    inst_fetch_queue #(
        .OUTSTANDING (OUT),
        .IBUF_DEPTH  (DEPTH),
        .RESET_PC    (RPC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .ifq   (ifq.master)
    );

    pend_t       mq[$];
    logic [70:0] bq[$];
    logic [31:0] m_pc;
    bit          m_hold;
    logic [70:0] dut_bus_q[$];
    int          dut_cyc_q[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          dut_pops = 0;

    task automatic chk(input string tag, input logic [70:0] got,
                       input logic [70:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] pc_of(input logic [70:0] b);
        return b[38:7];
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        ifq.inst_sram_addr_ok = 1'b0;
        ifq.inst_sram_data_ok = 1'b0;
        ifq.inst_sram_rdata   = '0;
        ifq.redirect          = 1'b0;
        ifq.redirect_pc       = '0;
        ifq.id_allowin        = 1'b0;
        mq.delete();
        bq.delete();
        dut_bus_q.delete();
        dut_cyc_q.delete();
        m_pc   = RPC;
        m_hold = 0;
        #1;
        chk("rst_req", ifq.inst_sram_req, 1'b0);
        chk("rst_valid", ifq.if_to_id_valid, 1'b0);
        chk("rst_bus", ifq.if_to_id_bus, '0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic step(input int p_aok, input int p_dok, input int p_allow,
                        input int p_redir, input logic [31:0] rp);
        logic [31:0] rpc;
        logic        exp_req;
        bit          misal;
        bit          adef;
        pend_t       p;
        @(negedge clk);
        rpc = RPC | (32'($urandom_range(255)) << 2);
        if ($urandom_range(4) == 0) rpc[1:0] = 2'($urandom_range(3, 1));
        if (rp != '0) rpc = rp;
        ifq.inst_sram_addr_ok = ($urandom_range(99) < p_aok);
        ifq.inst_sram_data_ok = (mq.size() > 0) && ($urandom_range(99) < p_dok);
        ifq.inst_sram_rdata   = (mq.size() > 0) ? mem_rd(mq[0].pc) : $urandom;
        ifq.id_allowin        = ($urandom_range(99) < p_allow);
        ifq.redirect          = ($urandom_range(99) < p_redir);
        ifq.redirect_pc       = rpc;
        #1;
        misal = 0;
`ifdef IFQ_ADEF_EN
        misal = (m_pc[1:0] != 2'b00) || m_hold;
`endif
        exp_req = (mq.size() < OUT) && (mq.size() + bq.size() < DEPTH)
                && !ifq.redirect && !misal;
        chk("req", ifq.inst_sram_req, exp_req);
        if (exp_req) chk("addr", ifq.inst_sram_addr, m_pc);
        chk("valid", ifq.if_to_id_valid, bq.size() > 0);
        if (bq.size() > 0) chk("bus", ifq.if_to_id_bus, bq[0]);
        if (ifq.if_to_id_valid && ifq.id_allowin && !ifq.redirect) begin
            dut_bus_q.push_back(ifq.if_to_id_bus);
            dut_cyc_q.push_back(cyc);
            dut_pops++;
        end
        adef = 0;
`ifdef IFQ_ADEF_EN
        adef = (m_pc[1:0] != 2'b00) && !m_hold && !ifq.redirect
             && mq.size() == 0 && bq.size() < DEPTH;
`endif
        if (bq.size() > 0 && ifq.id_allowin && !ifq.redirect)
            void'(bq.pop_front());
        if (ifq.inst_sram_data_ok) begin
            p = mq.pop_front();
            if (!ifq.redirect && !p.cxl)
                bq.push_back({mem_rd(p.pc), p.pc, 1'b0, 6'h0});
        end
        if (adef) begin
            bq.push_back({32'h0, m_pc, 1'b1, 6'h08});
            m_hold = 1;
        end
        if (ifq.redirect) begin
            bq.delete();
            foreach (mq[i]) mq[i].cxl = 1;
            m_pc   = ifq.redirect_pc;
            m_hold = 0;
        end else if (exp_req && ifq.inst_sram_addr_ok) begin
            mq.push_back('{m_pc, 1'b0});
            m_pc = m_pc + 32'd4;
        end
        cyc++;
    endtask

    initial begin
        reset = 1'b1;
        do_reset();

        // back-to-back fetch stream from reset
        repeat (8) step(100, 100, 100, 0, '0);
        chk("d1_beats", dut_bus_q.size() >= 3, 1'b1);
        if (dut_bus_q.size() >= 3) begin
            chk("d1_pc0", pc_of(dut_bus_q[0]), RPC);
            chk("d1_pc1", pc_of(dut_bus_q[1]), RPC + 32'd4);
            chk("d1_pc2", pc_of(dut_bus_q[2]), RPC + 32'd8);
            chk("d1_cyc1", dut_cyc_q[1], dut_cyc_q[0] + 1);
            chk("d1_cyc2", dut_cyc_q[2], dut_cyc_q[1] + 1);
        end

        // ID stalled: buffer fills to DEPTH, then drains intact
        do_reset();
        repeat (20) step(100, 100, 0, 0, '0);
        chk("d2_valid", ifq.if_to_id_valid, 1'b1);
        chk("d2_req", ifq.inst_sram_req, 1'b0);
        dut_pops = 0;
        repeat (8) step(0, 100, 100, 0, '0);
        chk("d2_drain", dut_pops, DEPTH);

        // redirect with two requests in flight
        do_reset();
        repeat (2) step(100, 0, 100, 0, '0);
        step(0, 0, 100, 100, 32'h1c000100);
        dut_bus_q.delete();
        repeat (10) step(100, 100, 100, 0, '0);
        chk("d3_cnt", dut_bus_q.size() > 0, 1'b1);
        if (dut_bus_q.size() > 0)
            chk("d3_pc", pc_of(dut_bus_q[0]), 32'h1c000100);

        // redirect in the cycle a response returns
        do_reset();
        repeat (2) step(100, 0, 100, 0, '0);
        step(100, 100, 100, 100, 32'h1c000200);
        dut_bus_q.delete();
        repeat (10) step(100, 100, 100, 0, '0);
        chk("d4_cnt", dut_bus_q.size() > 0, 1'b1);
        if (dut_bus_q.size() > 0)
            chk("d4_pc", pc_of(dut_bus_q[0]), 32'h1c000200);

        // misaligned redirect target
        do_reset();
        repeat (2) step(100, 0, 100, 0, '0);
        step(0, 0, 100, 100, 32'h1c000102);
        dut_bus_q.delete();
        repeat (10) step(100, 100, 100, 0, '0);
        chk("d5_cnt", dut_bus_q.size() > 0, 1'b1);
`ifdef IFQ_ADEF_EN
        if (dut_bus_q.size() > 0)
            chk("d5_adef", dut_bus_q[0], {32'h0, 32'h1c000102, 1'b1, 6'h08});
        chk("d5_hold", ifq.inst_sram_req, 1'b0);
`else
        if (dut_bus_q.size() > 1) begin
            chk("d5_pc0", pc_of(dut_bus_q[0]), 32'h1c000102);
            chk("d5_pc1", pc_of(dut_bus_q[1]), 32'h1c000106);
        end
`endif

        // random traffic with a mid-run reset
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            step($urandom_range(100), $urandom_range(100),
                 $urandom_range(100), 5, '0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
